// File: rtl/fifo_sample_reader.sv
// Drains a registered-read sync FIFO into a 2-entry skid buffer and presents sign-extended
// samples over valid/ready. Optional sample counter enabled by FIFO_READER_CNT_EN.
module fifo_sample_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk30x,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_cs,
    output logic              fifo_rd_en,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef FIFO_READER_CNT_EN
    output logic [15:0]       sample_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [RD_LAT-1:0]  tag_q, tag_d;
    logic [RD_LAT:0]    tag_shift;
    logic [1:0]         occ_q, occ_d;
    logic [OUT_W-1:0]   buf0_q, buf0_d;
    logic [OUT_W-1:0]   buf1_q, buf1_d;
    logic [2:0]         inflight;
    logic               push, pop, credit_ok;
    logic [OUT_W-1:0]   ext_data;

    assign ext_data  = {{(OUT_W-DATA_W){fifo_dout[DATA_W-1]}}, fifo_dout};
    assign push      = tag_q[RD_LAT-1];
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;
    assign pop       = out_valid & out_ready;

    // A slot being popped this cycle is reusable, which is what sustains one sample per cycle.
    assign credit_ok = ({1'b0, occ_q} + inflight) < (3'd2 + {2'b00, pop});

    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, tag_q[i]};
        end
    end

    always_comb begin
        state_d    = state_q;
        fifo_rd_cs = (state_q != StIdle);
        busy       = (state_q != StIdle);
        fifo_rd_en = (state_q == StRun) & ~fifo_empty & credit_ok;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StDrain;
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if ((inflight == 3'd0) && (occ_q == 2'd0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tag_shift = {tag_q, fifo_rd_en};
        tag_d     = tag_shift[RD_LAT-1:0];
    end

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = ext_data;
                else               buf1_d = ext_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = ext_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ext_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk30x) begin
        if (rst) begin
            state_q <= StIdle;
            tag_q   <= '0;
            occ_q   <= 2'd0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            occ_q   <= occ_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d      = pop ? cnt_q + 16'd1 : cnt_q;
    assign sample_cnt = cnt_q;

    always_ff @(posedge clk30x) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Directed bench for fifo_sample_reader with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_sample_reader;

    logic        clk30x = 1'b0;
    logic        rst, en, out_ready;
    logic        fifo_empty, fifo_rd_cs, fifo_rd_en, out_valid, busy;
    logic [15:0] fifo_dout = 16'h0000;
    logic [31:0] out_data;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] sample_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] fmem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [31:0] rmem [0:63];
    int          rcnt = 0;

    always #5 clk30x = ~clk30x;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk30x) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_dout <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk30x) begin
        if (!rst && out_valid && out_ready) begin
            rmem[rcnt] <= out_data;
            rcnt       <= rcnt + 1;
        end
    end

    fifo_sample_reader dut (
        .clk30x     (clk30x),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef FIFO_READER_CNT_EN
        .sample_cnt (sample_cnt),
`endif
        .busy       (busy)
    );

    task automatic push(input logic [15:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; out_ready = 1'b1;
        push(16'h0001); push(16'h7FFF); push(16'h8000); push(16'hFFFF);
        repeat (2) @(negedge clk30x);
        n_cmp++; if (fifo_rd_cs !== 1'b0) begin n_err++; $display("FAIL reset_rd_cs: got %b want 0", fifo_rd_cs); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL release_rd_en_early: got %b want 0", fifo_rd_en); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_s [4];
        exp_s[0] = 32'h00000001; exp_s[1] = 32'h00007FFF;
        exp_s[2] = 32'hFFFF8000; exp_s[3] = 32'hFFFFFFFF;
        @(negedge clk30x);
        n_cmp++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL stream_first_rd_en: got %b want 1", fifo_rd_en); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stream_busy: got %b want 1", busy); end
        @(negedge clk30x);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_early: got %b want 0", out_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk30x);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
            n_cmp++; if (out_data !== exp_s[k]) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", k, out_data, exp_s[k]); end
        end
        @(negedge clk30x);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid_end: got %b want 0", out_valid); end
    endtask

    task automatic test_empty_stall();
        int          r0;
        logic [31:0] exp_e [3];
        exp_e[0] = 32'h00000011; exp_e[1] = 32'hFFFF8022; exp_e[2] = 32'h00000033;
        r0 = rcnt;
        push(16'h0011); push(16'h8022); push(16'h0033);
        repeat (8) @(negedge clk30x);
        n_cmp++; if (rcnt - r0 !== 3) begin n_err++; $display("FAIL empty_count: got %0d want 3", rcnt - r0); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rmem[r0+k] !== exp_e[k]) begin n_err++; $display("FAIL empty_data[%0d]: got %h want %h", k, rmem[r0+k], exp_e[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk30x);
            n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL empty_rd_en[%0d]: got %b want 0", k, fifo_rd_en); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid[%0d]: got %b want 0", k, out_valid); end
        end
        push(16'h1234);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk30x);
            if (out_valid) break;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL resume_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h00001234) begin n_err++; $display("FAIL resume_data: got %h want 00001234", out_data); end
        @(negedge clk30x);
    endtask

    task automatic test_back_pressure();
        int          p0, r0;
        logic [31:0] exp_b [8];
        exp_b[0] = 32'h00000101; exp_b[1] = 32'hFFFFF102; exp_b[2] = 32'h00000103;
        exp_b[3] = 32'hFFFFF104; exp_b[4] = 32'h00000105; exp_b[5] = 32'hFFFFF106;
        exp_b[6] = 32'h00000107; exp_b[7] = 32'hFFFFF108;
        out_ready = 1'b0;
        p0 = rd_ptr;
        r0 = rcnt;
        push(16'h0101); push(16'hF102); push(16'h0103); push(16'hF104);
        push(16'h0105); push(16'hF106); push(16'h0107); push(16'hF108);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk30x);
            if (out_valid) begin
                n_cmp++; if (out_data !== exp_b[0]) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want %h", k, out_data, exp_b[0]); end
            end
        end
        n_cmp++; if (rd_ptr - p0 !== 2) begin n_err++; $display("FAIL bp_reads: got %0d want 2", rd_ptr - p0); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk30x);
            if (rcnt >= r0 + 8) break;
        end
        n_cmp++; if (rcnt - r0 !== 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", rcnt - r0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (rmem[r0+k] !== exp_b[k]) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", k, rmem[r0+k], exp_b[k]); end
        end
        @(negedge clk30x);
    endtask

    task automatic test_drain();
        int p0, r0;
        out_ready = 1'b0;
        r0 = rcnt;
        push(16'hABCD); push(16'h0042);
        repeat (4) @(negedge clk30x);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_pre_valid: got %b want 1", out_valid); end
        push(16'h5555);
        p0 = rd_ptr;
        en = 1'b0;
        @(negedge clk30x);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b want 1", busy); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL drain_rd_en0: got %b want 0", fifo_rd_en); end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk30x);
            n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL drain_rd_en[%0d]: got %b want 0", k, fifo_rd_en); end
            if (!busy) break;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_idle: got %b want 0", busy); end
        n_cmp++; if (fifo_rd_cs !== 1'b0) begin n_err++; $display("FAIL drain_rd_cs: got %b want 0", fifo_rd_cs); end
        n_cmp++; if (rcnt - r0 !== 2) begin n_err++; $display("FAIL drain_count: got %0d want 2", rcnt - r0); end
        n_cmp++; if (rmem[r0] !== 32'hFFFFABCD) begin n_err++; $display("FAIL drain_data0: got %h want FFFFABCD", rmem[r0]); end
        n_cmp++; if (rmem[r0+1] !== 32'h00000042) begin n_err++; $display("FAIL drain_data1: got %h want 00000042", rmem[r0+1]); end
        n_cmp++; if (rd_ptr !== p0) begin n_err++; $display("FAIL drain_no_read: got %0d want %0d", rd_ptr, p0); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        push(16'h7777);
        en = 1'b1;
        repeat (5) @(negedge clk30x);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk30x);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en); end
`ifdef FIFO_READER_CNT_EN
        n_cmp++; if (sample_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_cnt: got %h want 0", sample_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk30x);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_after_valid: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_empty_stall();
        test_back_pressure();
        test_drain();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
